// File: rtl/systolic_lif_array_if.sv
// ---------------------------------------------------------------------------
// systolic_lif_array_if
//   Token/monitor bundle between the pin wrapper and the systolic LIF array.
//
//   Signals
//     in_valid    token present at stage 0
//     in_current  token current (IN_W)
//     threshold   firing threshold shared by all stages (V_W)
//     mode        0 = broadcast, 1 = cascade
//     mon_sel     stage whose membrane is shown on v_mon
//     spike_out   per-stage registered spike pulse (N)
//     out_valid   token has left the last stage
//     v_mon       membrane of stage mon_sel (V_W)
//
//   Modports
//     master  drives the token/config side, observes the outputs
//     slave   the array itself
// ---------------------------------------------------------------------------
interface systolic_lif_array_if #(
    parameter int N    = 4,
    parameter int IN_W = 8,
    parameter int V_W  = 10
);
    localparam int SEL_W = $clog2(N);

    logic                 in_valid;
    logic [IN_W-1:0]      in_current;
    logic [V_W-1:0]       threshold;
    logic                 mode;
    logic [SEL_W-1:0]     mon_sel;
    logic [N-1:0]         spike_out;
    logic                 out_valid;
    logic [V_W-1:0]       v_mon;

    modport master (
        output in_valid, in_current, threshold, mode, mon_sel,
        input  spike_out, out_valid, v_mon
    );

    modport slave (
        input  in_valid, in_current, threshold, mode, mon_sel,
        output spike_out, out_valid, v_mon
    );
endinterface

// File: rtl/systolic_lif_array.sv
// ---------------------------------------------------------------------------
// systolic_lif_array
//   Linear chain of N leaky integrate-and-fire stages. A token enters stage 0
//   and moves one stage per enabled clock. In broadcast mode every stage sees
//   the token's original current; in cascade mode a stage receives KICK when
//   its upstream neighbour fired on that token, else 0.
//
//   Optional feature: define REFRACTORY_EN to give each stage a refractory
//   counter. After a spike the stage ignores the next REFRAC valid tokens
//   (V forced to 0, no spike) while still forwarding them.
//
//   Ports
//     clk    clock
//     rst_n  synchronous active-low reset
//     ena    global enable; low freezes every register
//     bus    systolic_lif_array_if.slave (token in, spikes/monitor out)
// ---------------------------------------------------------------------------
module systolic_lif_array #(
    parameter int N       = 4,
    parameter int IN_W    = 8,
    parameter int V_W     = 10,
    parameter int LEAK_SH = 2,
    parameter int KICK    = 255,
    parameter int REFRAC  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    systolic_lif_array_if.slave bus
);
    localparam logic [IN_W-1:0] KICK_C = IN_W'(KICK);

    // vld_pipe[i] is the input valid of stage i; vld_pipe[N] leaves the chain
    logic [N:0]                 vld_pipe;
    logic [N-1:0][V_W-1:0]      v_q;
    logic [N-1:0][IN_W-1:0]     x_q;
    logic [N-1:0]               spk_q;

    assign vld_pipe[0] = bus.in_valid & ena;

    for (genvar i = 0; i < N; i++) begin : g_stage
        logic [V_W-1:0]  v_r;
        logic            vld_r;
        logic [IN_W-1:0] x_r;
        logic            spk_r;
        logic [IN_W-1:0] cur;
        logic [V_W:0]    sum;
        logic [V_W-1:0]  sat;
        logic            fire;

        if (i == 0) begin : g_head
            assign cur = bus.in_current;
        end else begin : g_body
            // mode is looked at as the token crosses this boundary
            assign cur = bus.mode ? (spk_q[i-1] ? KICK_C : '0) : x_q[i-1];
        end

        // V - leak never exceeds V, so one extra bit holds the sum
        always_comb begin
            sum  = {1'b0, v_r} - {1'b0, (v_r >> LEAK_SH)}
                 + {{(V_W+1-IN_W){1'b0}}, cur};
            sat  = sum[V_W] ? {V_W{1'b1}} : sum[V_W-1:0];
            fire = (sat >= bus.threshold);
        end

`ifdef REFRACTORY_EN
        localparam int REF_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
        logic [REF_W-1:0] ref_r;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r   <= '0;
                vld_r <= 1'b0;
                x_r   <= '0;
                spk_r <= 1'b0;
                ref_r <= '0;
            end else if (ena) begin
                if (vld_pipe[i]) begin
                    vld_r <= 1'b1;
                    x_r   <= cur;
                    if (ref_r != '0) begin
                        // silenced token: still forwarded, no integration
                        ref_r <= ref_r - 1'b1;
                        v_r   <= '0;
                        spk_r <= 1'b0;
                    end else if (fire) begin
                        spk_r <= 1'b1;
                        v_r   <= '0;
                        ref_r <= REF_W'(REFRAC);
                    end else begin
                        spk_r <= 1'b0;
                        v_r   <= sat;
                    end
                end else begin
                    vld_r <= 1'b0;
                    spk_r <= 1'b0;
                end
            end
        end
`else
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r   <= '0;
                vld_r <= 1'b0;
                x_r   <= '0;
                spk_r <= 1'b0;
            end else if (ena) begin
                if (vld_pipe[i]) begin
                    vld_r <= 1'b1;
                    x_r   <= cur;
                    if (fire) begin
                        spk_r <= 1'b1;
                        v_r   <= '0;
                    end else begin
                        spk_r <= 1'b0;
                        v_r   <= sat;
                    end
                end else begin
                    // no token: no leak, V holds
                    vld_r <= 1'b0;
                    spk_r <= 1'b0;
                end
            end
        end
`endif

        assign v_q[i]        = v_r;
        assign x_q[i]        = x_r;
        assign spk_q[i]      = spk_r;
        assign vld_pipe[i+1] = vld_r;
    end

`ifndef REFRACTORY_EN
    logic unused_refrac;
    assign unused_refrac = |REFRAC;
`endif

    assign bus.spike_out = spk_q;
    assign bus.out_valid = vld_pipe[N];
    assign bus.v_mon     = (int'(bus.mon_sel) < N) ? v_q[bus.mon_sel] : '0;
endmodule

// File: tb/tb_systolic_lif_array.sv
// ---------------------------------------------------------------------------
// tb_systolic_lif_array
//   Directed stimulus for systolic_lif_array. Each injected token pushes its
//   expected per-stage spikes and the expected membrane of the monitored
//   stage into a queue; a monitor pops one entry per token leaving the chain
//   and lines it up against its recorded history of spike_out / v_mon.
// ---------------------------------------------------------------------------
module tb_systolic_lif_array;
    localparam int N    = 4;
    localparam int IN_W = 8;
    localparam int V_W  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;

    always #5 clk = ~clk;

    systolic_lif_array_if #(.N(N), .IN_W(IN_W), .V_W(V_W)) bus ();

    systolic_lif_array #(
        .N(N), .IN_W(IN_W), .V_W(V_W), .LEAK_SH(2), .KICK(255), .REFRAC(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    typedef struct {
        logic [N-1:0]   spk;
        logic [V_W-1:0] v;
        int             sel;
        string          nm;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    endtask

    // Monitor: stage i of an exiting token was seen (N-1-i) enabled cycles ago
    initial begin : monitor
        logic [N-1:0]   hspk [N];
        logic [V_W-1:0] hv   [N];
        logic           adv, rst_seen;
        logic [N-1:0]   got_spk;
        logic [V_W-1:0] got_v;
        exp_t           e;
        for (int k = 0; k < N; k++) begin hspk[k] = '0; hv[k] = '0; end
        forever begin
            @(posedge clk);
            adv      = ena;
            rst_seen = !rst_n;
            @(negedge clk);
            if (rst_seen) begin
                for (int k = 0; k < N; k++) begin hspk[k] = '0; hv[k] = '0; end
            end else if (adv) begin
                if (bus.out_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        check("unexpected_exit", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        got_spk[N-1] = bus.spike_out[N-1];
                        for (int i = 0; i < N-1; i++) got_spk[i] = hspk[N-2-i][i];
                        if (e.sel == N-1) got_v = bus.v_mon;
                        else              got_v = hv[N-2-e.sel];
                        check({e.nm, "_spikes"}, 32'(got_spk), 32'(e.spk));
                        check({e.nm, "_v"},      32'(got_v),   32'(e.v));
                    end
                end
                for (int k = N-1; k > 0; k--) begin hspk[k] = hspk[k-1]; hv[k] = hv[k-1]; end
                hspk[0] = bus.spike_out;
                hv[0]   = bus.v_mon;
            end
        end
    end

    task automatic send(input logic [IN_W-1:0] cur, input logic [N-1:0] spk,
                        input logic [V_W-1:0] v, input string nm);
        exp_t e;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_current = cur;
        e.spk = spk; e.v = v; e.sel = int'(bus.mon_sel); e.nm = nm;
        q.push_back(e);
    endtask

    task automatic idle_drain(input string nm);
        int cnt;
        cnt = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (q.size() != 0 && cnt < 4*N) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        bus.in_valid   = 1'b0;
        bus.in_current = '0;
        bus.threshold  = 10'd100;
        bus.mode       = 1'b0;
        bus.mon_sel    = '0;
        ena            = 1'b1;
        rst_n          = 1'b0;

        // 1. reset, with a token presented during reset
        bus.in_valid   = 1'b1;
        bus.in_current = 8'd200;
        repeat (2) @(negedge clk);
        check("rst_spike_out", 32'(bus.spike_out), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_v_mon",     32'(bus.v_mon),     32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (N+2) @(negedge clk);
        check("rst_token_ignored_ov", 32'(bus.out_valid), 32'd0);
        check("rst_token_ignored_v",  32'(bus.v_mon),     32'd0);

        // 2. broadcast, latency of spikes and out_valid
        send(8'd200, 4'b1111, 10'd0, "bcast");
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("bcast_lat_spike", 32'(bus.spike_out), 32'(1 << (k-1)));
            check("bcast_lat_ov",    32'(bus.out_valid), 32'(k == N));
        end
        idle_drain("bcast");
        for (int s = 0; s < N; s++) begin
            bus.mon_sel = 2'(s);
            #1 check("bcast_all_v0", 32'(bus.v_mon), 32'd0);
        end
        bus.mon_sel = '0;

        // 3. leak integration on back-to-back tokens
        do_reset();
        send(8'd40, 4'b0000, 10'd40, "leak1");
        send(8'd40, 4'b0000, 10'd70, "leak2");
        send(8'd40, 4'b0000, 10'd93, "leak3");
        send(8'd40, 4'b1111, 10'd0,  "leak4");
        idle_drain("leak");

        // 4. cascade: sub-threshold token leaves downstream stages at 0
        do_reset();
        bus.mode = 1'b1;
        send(8'd50, 4'b0000, 10'd50, "casc50");
        idle_drain("casc50");
        for (int s = 1; s < N; s++) begin
            bus.mon_sel = 2'(s);
            #1 check("casc_down_v0", 32'(bus.v_mon), 32'd0);
        end
        bus.mon_sel = '0;
        send(8'd200, 4'b1111, 10'd0, "casc200");
        idle_drain("casc200");
        bus.mode = 1'b0;

        // threshold boundary: one below stays, exactly equal fires
        do_reset();
        send(8'd99, 4'b0000, 10'd99, "thr_below");
        idle_drain("thr_below");
        do_reset();
        send(8'd100, 4'b1111, 10'd0, "thr_equal");
        idle_drain("thr_equal");

        // threshold 0: a zero-current token still fires everywhere
        do_reset();
        bus.threshold = 10'd0;
        send(8'd0, 4'b1111, 10'd0, "thr_zero");
        idle_drain("thr_zero");
        bus.threshold = 10'd100;

        // 5. continuous strong tokens
        do_reset();
        for (int t = 0; t < 7; t++) begin
`ifdef REFRACTORY_EN
            send(8'd200, (t % 3 == 0) ? 4'b1111 : 4'b0000, 10'd0, "refrac");
`else
            send(8'd200, 4'b1111, 10'd0, "refrac");
`endif
        end
        idle_drain("refrac");

        // 6. freeze with ena low while in_valid pulses
        do_reset();
        send(8'd40, 4'b0000, 10'd40, "frz1");
        @(negedge clk);
        ena            = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_current = 8'd200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("frz_v_mon",     32'(bus.v_mon),     32'd40);
            check("frz_spike_out", 32'(bus.spike_out), 32'd0);
            check("frz_out_valid", 32'(bus.out_valid), 32'd0);
            bus.in_valid = (k % 2 == 1);
        end
        ena          = 1'b1;
        bus.in_valid = 1'b0;
        send(8'd40, 4'b0000, 10'd70, "frz2");
        idle_drain("frz");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/systolic_lif_array.md
# systolic_lif_array

Parametrised successor to the single-configuration systolic LIF core. A linear chain of N leaky integrate-and-fire neuron stages passes input tokens one stage per clock. It adds two features: a runtime-selectable broadcast/cascade mode, and an optional refractory period. It sits behind the top-level pin wrapper, which maps `ui_in`/`uio_in` to the current/threshold inputs and `spike_out` to `uo_out`.

## Interface
Parameters:
- `N`, 4: number of neuron stages (≥2).
- `IN_W`, 8: input current width.
- `V_W`, 10: membrane potential width (> `IN_W`).
- `LEAK_SH`, 2: leak shift; leak = V >> `LEAK_SH`.
- `KICK`, 255: current (`IN_W` bits) forwarded downstream after a spike in cascade mode.
- `REFRAC`, 2: refractory length in valid tokens (used only with `REFRACTORY_EN`).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ena`  in  1  global enable; low freezes all state.
- `in_valid`  in  1  token present at stage 0.
- `in_current`  in  `IN_W`  token current.
- `threshold`  in  `V_W`  firing threshold, shared by all stages.
- `mode`  in  1  0 = broadcast, 1 = cascade.
- `mon_sel`  in  `$clog2(N)`  stage selected for `v_mon`.
- `spike_out`  out  `N`  per-stage spike pulse, registered.
- `out_valid`  out  1  token has left stage N-1.
- `v_mon`  out  `V_W`  membrane of stage `mon_sel`, combinational mux of registered V.

## Operation
- Per-stage state: `V[i]`, `valid[i]`, `x[i]` (forwarded current), `spk[i]`; `ref[i]` is added only with `REFRACTORY_EN`.
- Stage inputs:
  - Stage 0: valid = `in_valid & ena`, current = `in_current`.
  - Stage i>0: valid = `valid[i-1]`.
  - Stage i>0 current: `x[i-1]` when `mode`=0; `spk[i-1] ? KICK : 0` when `mode`=1.
- Each stage is evaluated only when its input valid is high. Its update:
  - sum = V − (V >> `LEAK_SH`) + current, computed in `V_W`+1 bits.
  - sum saturates to 2^`V_W`−1.
  - If sum ≥ `threshold`: `spk`=1 and V←0. Otherwise `spk`=0 and V←sum.
  - `valid[i]`←1. `x[i]`←the stage's input current.
- Stage input invalid: `valid[i]`←0, `spk[i]`←0, V holds. There is no leak without a token.
- `threshold`=0: every valid token fires.
- `mode` is sampled each cycle at each stage boundary. Changing it mid-stream affects only tokens crossing a boundary after the change.
- `spike_out[i]` = `spk[i]`; `out_valid` = `valid[N-1]`.
- `ena` low: no register changes and `in_valid` is ignored. Outputs hold their last values, including pulses.

## Timing
- Reset (`rst_n` low at a `clk` edge): all V, `valid`, `x`, `spk` and `ref` clear to 0.
  - `spike_out`=0, `out_valid`=0; `v_mon`=0 the cycle after.
  - Reset mid-stream discards in-flight tokens.
- A token accepted at edge t produces `spike_out[i]` valid after edge t+1+i. `out_valid` rises after edge t+N.
- Throughput: one token per cycle. Back-to-back tokens never collide.
- Spike pulses last 1 cycle per token, unless held by `ena` low.

## Configuration
- `REFRACTORY_EN` defined:
  - After a spike, `ref[i]`←`REFRAC`.
  - While `ref[i]`≠0, each valid token decrements `ref[i]`, forces V=0 and `spk`=0, and is still forwarded.
  - In cascade mode the forwarded current is 0.
- `REFRACTORY_EN` undefined: no `ref` registers; a stage may fire on consecutive tokens.

## Test plan
Defaults: N=4, IN_W=8, V_W=10, LEAK_SH=2, threshold=100, `ena`=1.
1. Reset: hold `rst_n`=0 for 2 clocks → `spike_out`=0, `out_valid`=0, `v_mon`=0; then a token 200 injected during reset is ignored.
2. Broadcast: one token 200 at edge t → `spike_out[0]` after t+1, `spike_out[1]` after t+2, … `spike_out[3]` and `out_valid` after t+4; all V=0.
3. Leak integration, stage 0, `mon_sel`=0: tokens 40 on consecutive cycles → `v_mon` reads 40, 70, 93, then spike on token 4 (sum 110) with V=0.
4. Cascade (`mode`=1): token 200 → all four stages spike in successive cycles (KICK=255 ≥ 100). Token 50 → stage 0 V=50, no spikes, stages 1–3 V stay 0.
5. Refractory (`REFRACTORY_EN`, REFRAC=2): tokens 200 every cycle → `spike_out[0]` high on tokens 1, 4, 7 only. Without the macro it is high on every token.
6. Freeze: inject 40, drop `ena` for 3 cycles while pulsing `in_valid` with 200 → `v_mon` stays 40 and no outputs change; after re-enable, next token 40 → `v_mon` 70.
